decoder_scan_ctrl: RTL

DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

---
 rtl/decoder_scan_pkg.sv | 15 +
 rtl/decoder_scan_ctrl_chan_pick.sv | 35 +++
 rtl/decoder_scan_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared definitions for the decoder scan controller.
// Holds the FSM state encoding, the channel count and the width of a
// channel index. Imported by decoder_scan_ctrl and chan_pick.
package decoder_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_chan_pick.sv
// chan_pick: combinational channel selector for the scan controller.
// Ports:
//   mask     - channel-enable bits, bit i = channel i
//   idx      - current channel index
//   next_idx - lowest enabled channel strictly above idx (valid when found)
//   found    - 1 when such a higher enabled channel exists
//   low_idx  - lowest enabled channel in mask (0 when mask is empty)
module chan_pick
    import decoder_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   idx,
    output logic [CH_W-1:0]   next_idx,
    output logic              found,
    output logic [CH_W-1:0]   low_idx
);

    // Walking from the top channel down, the last hit is the lowest one,
    // both for "any enabled" and for "enabled and above idx".
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        low_idx  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = CH_W'(i);
                if (i > int'(idx)) begin
                    next_idx = CH_W'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: drives a 2-to-4 decoder (select a/b, enable en) to
// scan the channels enabled in chan_mask, holding en high for dwell+1
// cycles per channel with a one-cycle en=0 gap between channels.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - scan request, accepted only in IDLE
//   stop            - abort, forces IDLE from any state
//   cont            - continuous (wrapping) mode, latched at start
//   chan_mask       - channel enables, latched at start
//   dwell           - enable-high time minus one, latched at start
//   a, b            - decoder select (a = index bit 1, b = index bit 0)
//   en              - decoder enable
//   busy            - high whenever not IDLE
//   done            - one-cycle pulse when a single-mode scan completes
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NUM_CH-1:0]  chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               en,
    output logic               busy,
    output logic               done
);

    state_t               state_q, state_d;
    logic [CH_W-1:0]      chan_q, chan_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 cont_q, cont_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;

    logic [NUM_CH-1:0]    pick_mask;
    logic [CH_W-1:0]      next_idx;
    logic                 found;
    logic [CH_W-1:0]      low_idx;

    // In IDLE the live mask is what gets latched; afterwards only the
    // latched copy matters, so one selector serves both cases.
    assign pick_mask = (state_q == IDLE) ? chan_mask : mask_q;

    chan_pick u_pick (
        .mask     (pick_mask),
        .idx      (chan_q),
        .next_idx (next_idx),
        .found    (found),
        .low_idx  (low_idx)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d = state_q;
        chan_d  = chan_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        cont_d  = cont_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;

        case (state_q)
            IDLE: begin
                chan_d = '0;
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (start && !stop && (chan_mask != '0)) begin
                    state_d = ACTIVE;
                    chan_d  = low_idx;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    cont_d  = cont;
                    mask_d  = chan_mask;
                    dwell_d = dwell;
                end
            end
            ACTIVE: begin
                if (cnt_q == dwell_q) begin
                    cnt_d = '0;
                    en_d  = 1'b0;
                    if (found) begin
                        state_d = GAP;
                        chan_d  = next_idx;
                    end else if (cont_q) begin
                        state_d = GAP;
                        chan_d  = low_idx;
                    end else begin
                        state_d = IDLE;
                        chan_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                // Select lines already settled during the gap; now enable.
                state_d = ACTIVE;
                en_d    = 1'b1;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                chan_d  = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides both a fresh start and dwell completion.
        if (stop) begin
            state_d = IDLE;
            chan_d  = '0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            chan_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            cont_q  <= 1'b0;
            mask_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
        end
    end

    assign a    = chan_q[1];
    assign b    = chan_q[0];
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
